// File: rtl/load_align_pkg.sv
// load_align_pkg: size codes, FSM states and lane-mask helper shared by the load alignment unit
package load_align_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    // Lanes off .. min(off+n, nb)-1 set; supports up to 8 byte lanes
    function automatic logic [7:0] lane_mask(input int unsigned off, input int unsigned n, input int unsigned nb);
        logic [7:0] m;
        for (int unsigned i = 0; i < 8; i++) m[i] = (i >= off) && (i < off + n) && (i < nb);
        return m;
    endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// load_extend: shifts merged beat data down by the byte offset and zero/sign-extends to DW bits
module load_extend #(
    parameter int DW = 32
) (
    input  logic [2*DW-1:0]           data_i,
    input  logic [$clog2(DW/8)-1:0]   off_i,
    input  logic [1:0]                size_i,
    input  logic                      unsigned_i,
    output logic [DW-1:0]             data_o
);
    localparam int NB = DW / 8;

    logic [DW-1:0] sh;
    logic          sign;

    assign sh = DW'(data_i >> {off_i, 3'b000});

    // Pick the top selected byte's MSB as sign, then fill lanes above n
    always_comb begin
        sign = 1'b0;
        for (int k = 0; k < NB; k++) if (k == (1 << size_i) - 1) sign = sh[8*k+7];
        sign = sign & ~unsigned_i;
        for (int k = 0; k < NB; k++) data_o[8*k+:8] = (k < (1 << size_i)) ? sh[8*k+:8] : {8{sign}};
    end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: one-at-a-time load path issuing one or two lane-masked bus reads and returning aligned, extended data.
// LOAD_MISALIGN_EN enables misaligned loads (lane-crossing ones take a second beat); otherwise misaligned loads return resp_err.
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int TW = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [TW-1:0]    req_tag_i,
    output logic             mem_req_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [DW/8-1:0]  mem_be_o,
    input  logic             mem_ack_i,
    input  logic [DW-1:0]    mem_rdata_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [DW-1:0]    resp_data_o,
    output logic [TW-1:0]    resp_tag_o,
    output logic             resp_err_o
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    state_e          state_q;
    logic [OW-1:0]   off_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            mem_req_q;
    logic [AW-1:0]   mem_addr_q;
    logic [NB-1:0]   mem_be_q;
    logic            resp_valid_q;
    logic [DW-1:0]   resp_data_q;
    logic [TW-1:0]   resp_tag_q;
    logic            resp_err_q;

    logic [OW-1:0]   in_off;
    logic            illegal;
    logic [2*DW-1:0] merged;
    logic [DW-1:0]   ext;

    assign in_off = req_addr_i[OW-1:0];

`ifdef LOAD_MISALIGN_EN
    logic [DW-1:0] beat0_q;
    logic          cross;
    assign cross   = 32'(off_q) + (32'd1 << size_q) > NB;
    assign illegal = (req_size_i == SZ_D) && (DW != 64);
    assign merged  = (state_q == BEAT1) ? {mem_rdata_i, beat0_q} : {{DW{1'b0}}, mem_rdata_i};
`else
    logic misal;
    assign misal   = |(in_off & OW'((32'd1 << req_size_i) - 32'd1));
    assign illegal = ((req_size_i == SZ_D) && (DW != 64)) || misal;
    assign merged  = {{DW{1'b0}}, mem_rdata_i};
`endif

    load_extend #(.DW(DW)) u_extend (
        .data_i     (merged),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext)
    );

    assign req_ready_o  = (state_q == IDLE);
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_tag_o   = resp_tag_q;
    assign resp_err_o   = resp_err_q;

    // Load FSM: accept, drive bus beats, merge/extend on final ack, hold result until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            off_q        <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= 1'b0;
`ifdef LOAD_MISALIGN_EN
            beat0_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    off_q      <= in_off;
                    size_q     <= req_size_i;
                    uns_q      <= req_unsigned_i;
                    resp_tag_q <= req_tag_i;
                    if (illegal) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        state_q    <= BEAT0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {req_addr_i[AW-1:OW], {OW{1'b0}}};
                        mem_be_q   <= NB'(lane_mask(32'(in_off), 32'd1 << req_size_i, NB));
                    end
                end
                BEAT0: if (mem_ack_i) begin
`ifdef LOAD_MISALIGN_EN
                    if (cross) begin
                        state_q    <= BEAT1;
                        beat0_q    <= mem_rdata_i;
                        mem_addr_q <= mem_addr_q + AW'(NB);
                        mem_be_q   <= NB'(lane_mask(0, 32'(off_q) + (32'd1 << size_q) - NB, NB));
                    end else
`endif
                    begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        mem_be_q     <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= ext;
                    end
                end
`ifdef LOAD_MISALIGN_EN
                BEAT1: if (mem_ack_i) begin
                    state_q      <= RESP;
                    mem_req_q    <= 1'b0;
                    mem_be_q     <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= ext;
                end
`endif
                RESP: if (resp_ready_i) begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Sequential load-path unit between the execute stage and the data-memory bus. It replaces the old combinational load byte-enable decoder. It accepts one load request at a time and issues one or two bus reads with per-lane byte enables. It then merges, shifts and sign- or zero-extends the returned bytes and holds the result until the writeback stage takes it. Data width is parametrised (32/64), and the optional misaligned support splits lane-crossing loads into two beats.

## Interface
- DW, 32, data/bus width in bits; legal 32 or 64; NB = DW/8 byte lanes, OW = log2(NB)
- AW, 32, address width
- TW, 5, destination-register tag width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready
- req_addr  in  AW  byte address
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (double legal only when DW=64)
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- req_tag  in  TW  destination tag, returned unchanged
- mem_req  out  1  bus read request, held until mem_ack
- mem_addr  out  AW  lane-aligned address (low OW bits 0)
- mem_be  out  NB  byte-lane enables
- mem_ack  in  1  single-cycle; mem_rdata valid in the same cycle
- mem_rdata  in  DW  read data
- resp_valid  out  1  result available, held until resp_ready
- resp_ready  in  1  writeback accepts
- resp_data  out  DW  aligned, extended load data
- resp_tag  out  TW  tag of the completed load
- resp_err  out  1  misaligned (macro off) or illegal size; resp_data = 0

## Operation
- Derived values: off = req_addr[OW-1:0], n = 1<<req_size bytes.
- A request is misaligned when (off & (n-1)) != 0. It crosses a lane when off+n > NB.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - req_ready = (state == IDLE).
  - Transitions:
    - IDLE -> BEAT0 on accept of a legal request.
    - IDLE -> RESP with resp_err=1 on accept of an illegal request.
    - BEAT0 -> BEAT1 on mem_ack if the request is crossing.
    - BEAT0 -> RESP on mem_ack otherwise.
    - BEAT1 -> RESP on mem_ack.
    - RESP -> IDLE on resp_ready.
- BEAT0 drives mem_addr = addr with low OW bits cleared. mem_be has bits off .. min(off+n, NB)-1 set.
- BEAT1 drives mem_addr = BEAT0 address + NB. mem_be has bits 0 .. off+n-NB-1 set.
- Lane address wrap at top of address space is modulo 2^AW.
- Merge and extend:
  - Selected bytes are concatenated in ascending address order (little-endian) and placed at bit 0.
  - Result is zero-extended if req_unsigned or n == NB; otherwise sign-extended from bit 8n-1.
- Request fields are captured at accept. Input changes during a transaction are ignored.

## Timing
- Reset values: state IDLE, so req_ready=1. mem_req=0, mem_addr=0, mem_be=0, resp_valid=0, resp_data=0, resp_tag=0, resp_err=0.
- All outputs are registered except req_ready.
- Accept at cycle T puts mem_req high at T+1. mem_ack may arrive in the first request cycle.
- Single beat, ack at T+1: resp_valid at T+2.
- Two beats, acks at T+1 and T+2: resp_valid at T+3. mem_req stays high across the beat change with no gap cycle.
- Illegal request: resp_valid at T+1 with no bus activity.
- A new request cannot be accepted while resp_valid is high. The earliest next accept is the cycle after resp_valid && resp_ready.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-transaction immediately forces all reset values. The pending bus read is abandoned, and the bus must tolerate a dropped request.

## Configuration
- LOAD_MISALIGN_EN defined:
  - Misaligned loads within one lane word complete in one beat.
  - Lane-crossing loads use BEAT1.
- Not defined:
  - Any misaligned request goes IDLE -> RESP with resp_err=1, resp_data=0.
  - BEAT1 logic is not generated.

## Structure
- Package load_align_pkg holds:
  - size encoding constants SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum
  - function lane_mask(off, n, NB)
- Sub-module load_extend is purely combinational. It takes the merged beat data, off, size and unsigned, and produces the aligned, extended DW-bit result.

## Test plan
- DW=32, lw addr 0x100, rdata 0x80FF1234, ack immediate -> mem_be 1111; resp_data 0x80FF1234 at T+2.
- DW=32, lb addr 0x103, rdata 0x80FF1234 -> mem_be 1000; resp_data 0xFFFFFF80. Same with lbu -> 0x00000080.
- DW=32, lh addr 0x102, rdata 0x80FF1234 -> mem_be 1100; resp_data 0xFFFF80FF.
- LOAD_MISALIGN_EN, DW=32, lw addr 0x103; beat0 rdata 0xAA000000, beat1 rdata 0x00CCBBDD:
  - beat0 mem_be 1000 at 0x100; beat1 mem_be 0111 at 0x104.
  - resp_data 0xCCBBDDAA at T+3.
- Macro off, lh addr 0x101 -> no mem_req; resp_err=1, resp_data 0 at T+1. DW=32 with size 3 -> resp_err=1.
- resp_ready held low 5 cycles, then reset pulse during a BEAT0 wait:
  - resp held stable through the stall.
  - Reset clears all outputs; req_ready=1 after release.
